// File: rtl/reg_file_responder_pkg.sv
// Shared definitions for the register-file responder: sizes, request-vector
// bit positions and the dump sequencer state encoding.
package reg_file_responder_pkg;
   localparam int NUM_REGS   = 32;
   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 8;

   localparam int VB_RD1     = 2;
   localparam int VB_RD2     = 1;
   localparam int VB_WR      = 0;

   // Register the core treats as its program output.
   localparam int OUTPUT_REG = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } dump_state_e;
endpackage

// File: rtl/reg_file_responder_if.sv
// Bundle of request/response and dump signals between the core (master) and
// the register-file responder (slave).
//   requests : read_reg1, read_reg2, write_reg, data, valid_bits, err_clr, dump_start
//   responses: ready, out1, out2, output_valid, uninit_err,
//              dump_valid, dump_addr, dump_data, dump_done
interface reg_file_responder_if;
   import reg_file_responder_pkg::*;

   logic [ADDR_W-1:0] read_reg1;
   logic [ADDR_W-1:0] read_reg2;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] data;
   logic [2:0]        valid_bits;
   logic              err_clr;
   logic              dump_start;

   logic              ready;
   logic [DATA_W-1:0] out1;
   logic [DATA_W-1:0] out2;
   logic              output_valid;
   logic              uninit_err;
   logic              dump_valid;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_done;

   modport master (
      output read_reg1, read_reg2, write_reg, data, valid_bits, err_clr, dump_start,
      input  ready, out1, out2, output_valid, uninit_err,
             dump_valid, dump_addr, dump_data, dump_done
   );

   modport slave (
      input  read_reg1, read_reg2, write_reg, data, valid_bits, err_clr, dump_start,
      output ready, out1, out2, output_valid, uninit_err,
             dump_valid, dump_addr, dump_data, dump_done
   );
endinterface

// File: rtl/reg_file_dump_seq.sv
// Dump sequencer: walks the register index from 0 to NUM_REGS-1, one beat per
// cycle, then emits a single done pulse. Owns the request-ready gating.
//   clk, rst_n     : clock, async active-low reset
//   dump_start_i   : begin a dump (honoured only in IDLE)
//   ready_o        : requests may be accepted
//   dump_valid_o   : dump_addr_o is a live beat
//   dump_addr_o    : index of the current beat
//   dump_done_o    : one-cycle pulse after the last beat
//
// state | meaning
// IDLE  | serving requests, ready high
// DUMP  | one register per cycle, requests ignored
// DONE  | done pulse, requests still ignored
module reg_file_dump_seq
   import reg_file_responder_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dump_start_i,
   output logic              ready_o,
   output logic              dump_valid_o,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic              dump_done_o
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready_o      = 1'b0;
      dump_valid_o = 1'b0;
      dump_done_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (dump_start_i) begin
               state_d = DUMP;
               cnt_d   = '0;
            end
         end
         DUMP: begin
            dump_valid_o = 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         DONE: begin
            dump_done_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dump_addr_o = cnt_q;
endmodule

// File: rtl/reg_file_responder.sv
// Register-file responder: 32 x 8-bit storage with r0 fixed at zero, two
// registered read ports with write-first bypass, sticky uninitialised-read
// flag, and a serial dump of every register.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of reg_file_responder_if
module reg_file_responder
   import reg_file_responder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   reg_file_responder_if.slave  bus
);
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] written_q;
   logic [DATA_W-1:0]   out1_q, out1_d;
   logic [DATA_W-1:0]   out2_q, out2_d;
   logic                ov_q, ov_d;
   logic                err_q, err_d;

   logic                ready;
   logic                dump_valid;
   logic [ADDR_W-1:0]   dump_addr;
   logic                accept, rd1, rd2, wr, hit1, hit2, set_err;

   reg_file_dump_seq u_dump_seq (
      .clk          (clk),
      .rst_n        (rst_n),
      .dump_start_i (bus.dump_start),
      .ready_o      (ready),
      .dump_valid_o (dump_valid),
      .dump_addr_o  (dump_addr),
      .dump_done_o  (bus.dump_done)
   );

   always_comb begin
      accept = ready & (|bus.valid_bits);
      rd1    = accept & bus.valid_bits[VB_RD1];
      rd2    = accept & bus.valid_bits[VB_RD2];
      wr     = accept & bus.valid_bits[VB_WR];
      // A same-request write to the read index bypasses storage and also
      // counts as initialising it.
      hit1   = wr && (bus.write_reg == bus.read_reg1);
      hit2   = wr && (bus.write_reg == bus.read_reg2);

      out1_d = out1_q;
      if (rd1) begin
         if (bus.read_reg1 == '0) out1_d = '0;
         else if (hit1)           out1_d = bus.data;
         else                     out1_d = regs_q[bus.read_reg1];
      end
      out2_d = out2_q;
      if (rd2) begin
         if (bus.read_reg2 == '0) out2_d = '0;
         else if (hit2)           out2_d = bus.data;
         else                     out2_d = regs_q[bus.read_reg2];
      end
      ov_d = rd1 | rd2;

      set_err = (rd1 & ~written_q[bus.read_reg1] & ~hit1) |
                (rd2 & ~written_q[bus.read_reg2] & ~hit2);
      // Set has priority over clear so a coincident error is not lost.
      if (set_err)          err_d = 1'b1;
      else if (bus.err_clr) err_d = 1'b0;
      else                  err_d = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         written_q <= NUM_REGS'(1);
         out1_q    <= '0;
         out2_q    <= '0;
         ov_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (wr && bus.write_reg != '0) regs_q[bus.write_reg] <= bus.data;
         if (wr) written_q[bus.write_reg] <= 1'b1;
         out1_q <= out1_d;
         out2_q <= out2_d;
         ov_q   <= ov_d;
         err_q  <= err_d;
      end
   end

   assign bus.ready        = ready;
   assign bus.out1         = out1_q;
   assign bus.out2         = out2_q;
   assign bus.output_valid = ov_q;
   assign bus.uninit_err   = err_q;
   assign bus.dump_valid   = dump_valid;
   assign bus.dump_addr    = dump_addr;
   assign bus.dump_data    = dump_valid ? regs_q[dump_addr] : '0;
endmodule
